// File: rtl/fifo_rd_serializer.sv
// fifo_rd_serializer: pops wide words from a show-ahead FIFO and streams each
// word out as IN_WIDTH/OUT_WIDTH narrow beats, least-significant slice first.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   en           pop enable; a held word always drains, only new pops stop
//   fifo_empty   FIFO empty flag
//   fifo_r_data  FIFO head word (valid while fifo_empty=0)
//   fifo_r_en    combinational pop strobe back to the FIFO
//   out_valid    out_data carries a beat
//   out_ready    downstream accepts the beat
//   out_data     current beat
//   out_last     current beat is the final slice of its word
//   busy         a word is held (same as out_valid)
module fifo_rd_serializer #(
  parameter int unsigned IN_WIDTH  = 384,
  parameter int unsigned OUT_WIDTH = 48,
  parameter int unsigned CNT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 fifo_empty,
  input  logic [IN_WIDTH-1:0]  fifo_r_data,
  output logic                 fifo_r_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 busy
);

  localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(RATIO - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [IN_WIDTH-1:0]  shreg_q, shreg_d;
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;

  logic accept;
  logic done;

  // Output decode straight from the state flops.
  assign out_valid = (state_q == ST_SEND);
  assign busy      = out_valid;
  assign out_data  = shreg_q[OUT_WIDTH-1:0];
  assign out_last  = out_valid & (beat_cnt_q == LAST_CNT);

  // Next-state logic; a finishing word may reload in the same edge (no bubble).
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    beat_cnt_d = beat_cnt_q;

    accept    = out_valid & out_ready;
    done      = accept & (beat_cnt_q == LAST_CNT);
    // reset term keeps the pop strobe low for the whole time reset is held
    fifo_r_en = reset & en & ~fifo_empty & ((state_q == ST_IDLE) | done);

    if (fifo_r_en) begin
      shreg_d    = fifo_r_data;
      beat_cnt_d = '0;
      state_d    = ST_SEND;
    end else if (done) begin
      shreg_d    = shreg_q >> OUT_WIDTH;
      beat_cnt_d = '0;
      state_d    = ST_IDLE;
    end else if (accept) begin
      shreg_d    = shreg_q >> OUT_WIDTH;
      beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
